// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory: one dmem cycle per grant,
// registered ACK/RDATA/ERR, round-robin or P0-priority with a P1 anti-starvation limit.
module dmem_arbiter #(
   parameter int unsigned SIZE     = 32,
   parameter int unsigned ADDR_MAX = 252,
   parameter int unsigned RR_MODE  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_req0,
   input  logic            i_we0,
   input  logic [SIZE-1:0] i_a0,
   input  logic [SIZE-1:0] i_wd0,
   input  logic            i_req1,
   input  logic            i_we1,
   input  logic [SIZE-1:0] i_a1,
   input  logic [SIZE-1:0] i_wd1,
   output logic            o_ack0,
   output logic            o_ack1,
   output logic [SIZE-1:0] o_rdata,
   output logic            o_err,
   output logic            o_busy,
   output logic            o_mem_we,
   output logic [SIZE-1:0] o_mem_a,
   output logic [SIZE-1:0] o_mem_wd,
   input  logic [SIZE-1:0] i_mem_rd
);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   localparam logic [3:0]      W_MAX = 4'(MAX_WAIT);
   localparam logic [SIZE-1:0] A_MAX = SIZE'(ADDR_MAX);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [SIZE-1:0]   r_addr;
   logic [SIZE-1:0]   r_wd;
   logic              r_id;
   logic              r_rr_ptr;
   logic [3:0]        r_wait_cnt;
   logic              w_gnt1;
   logic              w_any;
   logic              w_legal;
   logic              w_access;

   assign w_legal = (r_addr[1:0] == 2'b00) && (r_addr <= A_MAX);

   always_comb begin
      w_next   = r_state;
      w_any    = i_req0 | i_req1;
      w_gnt1   = i_req1;
      w_access = 1'b0;
      if (i_req0 && i_req1) begin
         if (RR_MODE != 0) w_gnt1 = r_rr_ptr;
         else              w_gnt1 = (r_wait_cnt == W_MAX);
      end
      case (r_state)
         S_IDLE:   if (w_any) w_next = S_ACCESS;
         S_ACCESS: begin
            w_access = 1'b1;
            w_next   = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // dmem drive is combinational from state so an async reset drops MEM_WE immediately
   assign o_busy   = w_access;
   assign o_mem_we = w_access & r_we & w_legal;
   assign o_mem_a  = w_access ? r_addr : '0;
   assign o_mem_wd = w_access ? r_wd   : '0;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wd       <= '0;
         r_id       <= 1'b0;
         r_rr_ptr   <= 1'b0;
         r_wait_cnt <= '0;
         o_ack0     <= 1'b0;
         o_ack1     <= 1'b0;
         o_err      <= 1'b0;
         o_rdata    <= '0;
      end else begin
         o_ack0 <= 1'b0;
         o_ack1 <= 1'b0;
         o_err  <= 1'b0;
         if (r_state == S_IDLE && w_any) begin
            r_we     <= w_gnt1 ? i_we1 : i_we0;
            r_addr   <= w_gnt1 ? i_a1  : i_a0;
            r_wd     <= w_gnt1 ? i_wd1 : i_wd0;
            r_id     <= w_gnt1;
            r_rr_ptr <= ~w_gnt1;
         end
         // wait counter only ever steers fixed-priority mode
         if (!i_req1) begin
            r_wait_cnt <= '0;
         end else if (r_state == S_IDLE && w_any) begin
            if (w_gnt1)                 r_wait_cnt <= '0;
            else if (r_wait_cnt < W_MAX) r_wait_cnt <= r_wait_cnt + 4'd1;
         end
         if (r_state == S_ACCESS) begin
            o_ack0  <= ~r_id;
            o_ack1  <= r_id;
            o_err   <= ~w_legal;
            o_rdata <= (!r_we && w_legal) ? i_mem_rd : '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (round-robin and fixed priority),
// each with a behavioural dmem; drivers push expected ACKs, monitors pop and compare.
module tb_dmem_arbiter;

   typedef struct {
      logic        id;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // round-robin instance
   logic        rst_r = 1'b1;
   logic        req0_r = 0, we0_r = 0, req1_r = 0, we1_r = 0;
   logic [31:0] a0_r = '0, wd0_r = '0, a1_r = '0, wd1_r = '0;
   logic        ack0_r, ack1_r, err_r, busy_r, mwe_r;
   logic [31:0] rdata_r, ma_r, mwd_r, mrd_r;
   logic [31:0] mem_r [64];
   int          wr_cnt_r = 0;
   exp_t        q_r[$];

   // fixed-priority instance
   logic        rst_f = 1'b1;
   logic        req0_f = 0, we0_f = 0, req1_f = 0, we1_f = 0;
   logic [31:0] a0_f = '0, wd0_f = '0, a1_f = '0, wd1_f = '0;
   logic        ack0_f, ack1_f, err_f, busy_f, mwe_f;
   logic [31:0] rdata_f, ma_f, mwd_f, mrd_f;
   logic [31:0] mem_f [64];
   exp_t        q_f[$];

   dmem_arbiter #(.SIZE(32), .ADDR_MAX(252), .RR_MODE(1), .MAX_WAIT(4)) dut_rr (
      .i_clk(clk), .i_reset(rst_r),
      .i_req0(req0_r), .i_we0(we0_r), .i_a0(a0_r), .i_wd0(wd0_r),
      .i_req1(req1_r), .i_we1(we1_r), .i_a1(a1_r), .i_wd1(wd1_r),
      .o_ack0(ack0_r), .o_ack1(ack1_r), .o_rdata(rdata_r), .o_err(err_r), .o_busy(busy_r),
      .o_mem_we(mwe_r), .o_mem_a(ma_r), .o_mem_wd(mwd_r), .i_mem_rd(mrd_r));

   dmem_arbiter #(.SIZE(32), .ADDR_MAX(252), .RR_MODE(0), .MAX_WAIT(4)) dut_fx (
      .i_clk(clk), .i_reset(rst_f),
      .i_req0(req0_f), .i_we0(we0_f), .i_a0(a0_f), .i_wd0(wd0_f),
      .i_req1(req1_f), .i_we1(we1_f), .i_a1(a1_f), .i_wd1(wd1_f),
      .o_ack0(ack0_f), .o_ack1(ack1_f), .o_rdata(rdata_f), .o_err(err_f), .o_busy(busy_f),
      .o_mem_we(mwe_f), .o_mem_a(ma_f), .o_mem_wd(mwd_f), .i_mem_rd(mrd_f));

   assign mrd_r = mem_r[ma_r[7:2]];
   assign mrd_f = mem_f[ma_f[7:2]];

   always @(posedge clk) begin
      if (mwe_r) begin
         mem_r[ma_r[7:2]] = mwd_r;
         wr_cnt_r = wr_cnt_r + 1;
      end
      if (mwe_f) mem_f[ma_f[7:2]] = mwd_f;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic id, input logic err, input logic [31:0] rd);
      exp_t e;
      e.id = id; e.err = err; e.rdata = rd;
      return e;
   endfunction

   // monitors
   always @(negedge clk) begin
      if (ack0_r || ack1_r) begin
         chk("rr_dual_ack", {31'd0, ack0_r & ack1_r}, 32'd0);
         if (q_r.size() == 0) chk("rr_unexpected_ack", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q_r.pop_front();
            chk("rr_id", {31'd0, ack1_r}, {31'd0, e.id});
            chk("rr_err", {31'd0, err_r}, {31'd0, e.err});
            chk("rr_rdata", rdata_r, e.rdata);
         end
      end
      if (ack0_f || ack1_f) begin
         chk("fx_dual_ack", {31'd0, ack0_f & ack1_f}, 32'd0);
         if (q_f.size() == 0) chk("fx_unexpected_ack", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q_f.pop_front();
            chk("fx_id", {31'd0, ack1_f}, {31'd0, e.id});
            chk("fx_err", {31'd0, err_f}, {31'd0, e.err});
            chk("fx_rdata", rdata_f, e.rdata);
         end
      end
   end

   task automatic single(input logic port, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                         output int edges);
      logic got;
      @(negedge clk);
      q_r.push_back(mk(port, eerr, erd));
      if (!port) begin req0_r = 1; we0_r = we; a0_r = a; wd0_r = wd; end
      else       begin req1_r = 1; we1_r = we; a1_r = a; wd1_r = wd; end
      got = 0; edges = 0;
      while (!got && edges < 50) begin
         @(posedge clk); #1;
         edges++;
         if (port ? ack1_r : ack0_r) got = 1;
      end
      if (!port) req0_r = 0; else req1_r = 0;
      if (!got) chk("single_timeout", 32'd0, 32'd1);
   endtask

   // both requesters hold REQ until each has n0/n1 ACKs; also checks ACK spacing
   task automatic both(input int n0, input int n1);
      int c0, c1, cyc, last;
      c0 = 0; c1 = 0; cyc = 0; last = -1;
      @(negedge clk);
      req0_r = (n0 > 0); req1_r = (n1 > 0);
      while ((c0 < n0 || c1 < n1) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (ack0_r || ack1_r) begin
            if (last >= 0) chk("rr_ack_gap", 32'(cyc - last), 32'd2);
            last = cyc;
         end
         if (ack0_r) begin c0++; if (c0 == n0) req0_r = 0; end
         if (ack1_r) begin c1++; if (c1 == n1) req1_r = 0; end
      end
      req0_r = 0; req1_r = 0;
      if (c0 != n0 || c1 != n1) chk("both_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_reset_r();
      @(negedge clk); rst_r = 1;
      @(negedge clk); rst_r = 0;
   endtask

   initial begin
      int e;
      int wsnap;
      for (int i = 0; i < 64; i++) begin mem_r[i] = '0; mem_f[i] = '0; end
      mem_r[8] = 32'h1;
      mem_f[1] = 32'h11;
      mem_f[2] = 32'h22;

      #1;
      chk("rst_ack0", {31'd0, ack0_r}, 32'd0);
      chk("rst_busy", {31'd0, busy_r}, 32'd0);
      chk("rst_rdata", rdata_r, 32'd0);
      @(negedge clk); rst_r = 0; rst_f = 0;

      // 1: P0 write then read
      single(1'b0, 1'b1, 32'h10, 32'hCAFE, 1'b0, 32'h0, e);
      chk("t1_write_latency", 32'(e), 32'd2);
      single(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE, e);
      chk("t1_read_latency", 32'(e), 32'd2);

      // 2: round-robin, both held, 6 each
      pulse_reset_r();
      a0_r = 32'h10; we0_r = 0; a1_r = 32'h0; we1_r = 0;
      for (int i = 0; i < 6; i++) begin
         q_r.push_back(mk(1'b0, 1'b0, 32'hCAFE));
         q_r.push_back(mk(1'b1, 1'b0, 32'h0));
      end
      both(6, 6);

      // 3: fixed priority, MAX_WAIT=4: P0 x4, P1, P0 x4, P1
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) q_f.push_back(mk(1'b0, 1'b0, 32'h11));
         q_f.push_back(mk(1'b1, 1'b0, 32'h22));
      end
      begin
         int c0, c1, cyc;
         c0 = 0; c1 = 0; cyc = 0;
         @(negedge clk);
         a0_f = 32'h4; a1_f = 32'h8; req0_f = 1; req1_f = 1;
         while ((c0 < 8 || c1 < 2) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ack0_f) begin c0++; if (c0 == 8) req0_f = 0; end
            if (ack1_f) begin c1++; if (c1 == 2) req1_f = 0; end
         end
         req0_f = 0; req1_f = 0;
         if (c0 != 8 || c1 != 2) chk("fx_timeout", 32'd0, 32'd1);
      end

      // 4: rejected accesses
      wsnap = wr_cnt_r;
      single(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, e);
      single(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, e);
      single(1'b1, 1'b1, 32'h12, 32'hDEAD, 1'b1, 32'h0, e);
      single(1'b1, 1'b1, 32'h100, 32'hBEEF, 1'b1, 32'h0, e);
      chk("t4_no_mem_write", 32'(wr_cnt_r - wsnap), 32'd0);
      single(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE, e);

      // 5: reset during ACCESS of a write
      @(negedge clk);
      req0_r = 1; we0_r = 1; a0_r = 32'h20; wd0_r = 32'h55;
      @(posedge clk); #1;
      chk("t5_busy_pre", {31'd0, busy_r}, 32'd1);
      chk("t5_we_pre", {31'd0, mwe_r}, 32'd1);
      #2; rst_r = 1; req0_r = 0; we0_r = 0;
      #1;
      chk("t5_busy", {31'd0, busy_r}, 32'd0);
      chk("t5_mem_we", {31'd0, mwe_r}, 32'd0);
      chk("t5_mem_a", ma_r, 32'd0);
      chk("t5_mem_wd", mwd_r, 32'd0);
      chk("t5_ack", {30'd0, ack0_r, ack1_r}, 32'd0);
      chk("t5_err", {31'd0, err_r}, 32'd0);
      chk("t5_rdata", rdata_r, 32'd0);
      @(negedge clk); rst_r = 0;
      chk("t5_mem_kept", mem_r[8], 32'h1);
      a0_r = 32'h20; we0_r = 0; a1_r = 32'h0; we1_r = 0;
      q_r.push_back(mk(1'b0, 1'b0, 32'h1));
      q_r.push_back(mk(1'b1, 1'b0, 32'h0));
      both(1, 1);

      // 6: fill via P1, read back via P0
      for (int unsigned ad = 0; ad <= 248; ad += 4)
         single(1'b1, 1'b1, 32'(ad), 32'(ad), 1'b0, 32'h0, e);
      for (int unsigned ad = 0; ad <= 248; ad += 4)
         single(1'b0, 1'b0, 32'(ad), 32'h0, 1'b0, 32'(ad), e);

      repeat (4) @(negedge clk);
      chk("rr_queue_empty", 32'(q_r.size()), 32'd0);
      chk("fx_queue_empty", 32'(q_f.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
